// File: rtl/spi_mem_pkg.sv
// Shared encodings for the SPI memory bridge: command codes, FSM states and
// the layout of the status word returned by the STATUS command.
package spi_mem_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE  = 2'b00,
    CMD_READ   = 2'b01,
    CMD_STATUS = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WR_DATA,
    RD_WAIT,
    RD_DATA,
    STAT,
    DISCARD
  } state_e;

  // Status word is {err, cnt}: err in the MSB, the word count below it.
  localparam int STAT_CNT_LSB = 0;

  function automatic int stat_err_pos(input int dw);
    return dw - 1;
  endfunction

  function automatic int stat_cnt_width(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/spi_mem_bridge_ram.sv
// Single-port word memory: synchronous write, registered read (old data on
// a same-address write). Contents are deliberately not reset.
module spi_mem_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI slave clocked by the system clock giving burst WRITE/READ access to a
// word memory plus a STATUS readback of the previous burst's outcome.
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int CW      = stat_cnt_width(DATA_WIDTH);
  localparam int ERR_POS = stat_err_pos(DATA_WIDTH);
  localparam int MAXW    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BW      = $clog2(MAXW + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  xfer_q, xfer_d;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic                  miso_q, miso_d;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [ADDR_WIDTH-1:0] full_addr;
  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [CW-1:0]         cnt_inc;
  logic [DATA_WIDTH-1:0] stat_word;

  assign full_addr = {addr_q[ADDR_WIDTH-2:0], MOSI};
  assign addr_ok   = ({1'b0, full_addr} < DEPTH_EXT);
  assign addr_inc  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign ram_wdata = {rx_q[DATA_WIDTH-2:0], MOSI};

  always_comb begin
    stat_word = '0;
    stat_word[ERR_POS] = err_q;
    stat_word[STAT_CNT_LSB +: CW] = cnt_q;
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    bit_d    = bit_q;
    addr_d   = addr_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    xfer_d   = xfer_q;
    status_d = status_q;
    miso_d   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;

    if (SS_n) begin
      // End of frame: only bursts publish their outcome; partial words are lost.
      state_d = IDLE;
      if (xfer_q) begin
        status_d = stat_word;
      end
      xfer_d = 1'b0;
      err_d  = 1'b0;
      cnt_d  = '0;
      bit_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cmd_d   = {1'b0, MOSI};
          state_d = CMD;
        end
        CMD: begin
          cmd_d = {cmd_q[0], MOSI};
          bit_d = '0;
          case ({cmd_q[0], MOSI})
            CMD_WRITE, CMD_READ: begin
              state_d = ADDR;
              xfer_d  = 1'b1;
            end
            CMD_STATUS: begin
              state_d = STAT;
              tx_d    = status_q;
            end
            default: state_d = DISCARD;
          endcase
        end
        ADDR: begin
          addr_d = full_addr;
          bit_d  = bit_q + 1'b1;
          if (bit_q == BW'(ADDR_WIDTH - 1)) begin
            bit_d = '0;
            if (!addr_ok) begin
              err_d   = 1'b1;
              state_d = DISCARD;
            end else if (cmd_q == CMD_READ) begin
              ram_addr = full_addr;
              state_d  = RD_WAIT;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          rx_d  = ram_wdata;
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d  = '0;
            ram_we = 1'b1;
            addr_d = addr_inc;
            cnt_d  = cnt_inc;
          end
        end
        RD_WAIT: begin
          tx_d    = ram_rdata;
          addr_d  = addr_inc;
          bit_d   = '0;
          state_d = RD_DATA;
        end
        RD_DATA: begin
          // ram_addr already points at the next word, so rdata holds the
          // prefetched word by the time the current LSB goes out.
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          bit_d  = bit_q + 1'b1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d  = '0;
            tx_d   = ram_rdata;
            addr_d = addr_inc;
            cnt_d  = cnt_inc;
          end
        end
        STAT: begin
          if (bit_q < BW'(DATA_WIDTH)) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            bit_d  = bit_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      bit_q    <= '0;
      addr_q   <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      xfer_q   <= 1'b0;
      status_q <= '0;
      miso_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      bit_q    <= bit_d;
      addr_q   <= addr_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      xfer_q   <= xfer_d;
      status_q <= status_d;
      miso_q   <= miso_d;
    end
  end

  assign MISO = miso_q;

  spi_mem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Table-driven bench for spi_mem_bridge: two instances (depth 256 and 200)
// share the SPI stimulus; expected MISO bits flow through a scoreboard queue.
module tb_spi_mem_bridge;
  import spi_mem_pkg::*;

  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  cmd;
    logic [7:0]  addr;
    int          nbits;
    logic [31:0] wbits;
    int          nexp;
    logic [31:0] expbits;
  } vec_t;

  logic clk, rst, SS_n, MOSI;
  logic miso1, miso2, miso_sel, sel;
  int   n_pass, n_total;
  logic exp_q[$];
  vec_t vecs[$];
  int   split;

  assign miso_sel = sel ? miso2 : miso1;

  spi_mem_bridge #(.DATA_WIDTH(8), .MEM_DEPTH(256), .ADDR_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso1)
  );

  spi_mem_bridge #(.DATA_WIDTH(8), .MEM_DEPTH(200), .ADDR_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic edge_drive(input logic ss, input logic mosi);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic s, input logic [1:0] cmd,
                     input logic [7:0] addr, input int nbits, input logic [31:0] wbits,
                     input int nexp, input logic [31:0] expbits);
    vec_t v;
    v.name = name; v.sel = s; v.cmd = cmd; v.addr = addr;
    v.nbits = nbits; v.wbits = wbits; v.nexp = nexp; v.expbits = expbits;
    vecs.push_back(v);
  endtask

  // One framed transaction; every data-phase edge pops one expected MISO bit.
  task automatic txn(input string name, input logic [1:0] cmd, input logic [7:0] addr,
                     input int nbits, input logic [31:0] wbits);
    logic b, e;
    int   k;
    edge_drive(1'b0, cmd[1]);
    edge_drive(1'b0, cmd[0]);
    if (!cmd[1]) begin
      for (int i = 7; i >= 0; i--) edge_drive(1'b0, addr[i]);
    end
    for (int i = 0; i < nbits; i++) begin
      k = nbits - 1 - i;
      b = (k < 32) ? wbits[k] : 1'b0;
      edge_drive(1'b0, b);
      e = exp_q.pop_front();
      check($sformatf("%s_bit%0d", name, i), {31'd0, miso_sel}, {31'd0, e});
    end
    edge_drive(1'b1, 1'b0);
    check($sformatf("%s_end", name), {31'd0, miso_sel}, 32'd0);
  endtask

  // READ 0x10 interrupted by reset on the edge that would emit data bit 3.
  task automatic reset_seq();
    logic [7:0] a, d;
    a = 8'h10;
    d = 8'hA5;
    edge_drive(1'b0, 1'b0);
    edge_drive(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) edge_drive(1'b0, a[i]);
    edge_drive(1'b0, 1'b0);
    check("rs_wait", {31'd0, miso_sel}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      edge_drive(1'b0, 1'b0);
      check($sformatf("rs_bit%0d", i), {31'd0, miso_sel}, {31'd0, d[7-i]});
    end
    @(negedge clk);
    rst = 1'b1;
    SS_n = 1'b0;
    @(posedge clk);
    #1;
    check("rs_miso", {31'd0, miso_sel}, 32'd0);
    check("rs_state", 32'(dut1.state_q), 32'(IDLE));
    @(negedge clk);
    SS_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    sel = 1'b0; rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso1", {31'd0, miso1}, 32'd0);
    check("rst_miso2", {31'd0, miso2}, 32'd0);
    check("rst_state", 32'(dut1.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    add("st_rst",   1'b0, 2'b10, 8'h00,  9, 32'h0,    8,  32'h00);
    add("wr10",     1'b0, 2'b00, 8'h10, 16, 32'hA53C, 0,  32'h0);
    add("st_wr10",  1'b0, 2'b10, 8'h00,  9, 32'h0,    8,  32'h02);
    add("rd10",     1'b0, 2'b01, 8'h10, 17, 32'h0,    17, 32'h0A53C);
    add("wrff",     1'b0, 2'b00, 8'hFF, 16, 32'h1122, 0,  32'h0);
    add("rdff",     1'b0, 2'b01, 8'hFF, 17, 32'h0,    17, 32'h01122);
    add("st_rdff",  1'b0, 2'b10, 8'h00,  8, 32'h0,    8,  32'h02);
    add("wr20",     1'b0, 2'b00, 8'h20,  8, 32'h77,   0,  32'h0);
    add("st_wr20",  1'b0, 2'b10, 8'h00,  8, 32'h0,    8,  32'h01);
    add("wr20_part",1'b0, 2'b00, 8'h20,  4, 32'h5,    0,  32'h0);
    add("st_part",  1'b0, 2'b10, 8'h00,  8, 32'h0,    8,  32'h00);
    add("rd20",     1'b0, 2'b01, 8'h20,  9, 32'h0,    9,  32'h077);
    add("rsvd",     1'b0, 2'b11, 8'h00, 10, 32'h3FF,  0,  32'h0);
    add("st_rsvd",  1'b0, 2'b10, 8'h00,  8, 32'h0,    8,  32'h01);
    split = vecs.size();
    add("st_after_rst", 1'b0, 2'b10, 8'h00, 8, 32'h0, 8, 32'h00);
    add("rd10_again",   1'b0, 2'b01, 8'h10, 9, 32'h0, 9, 32'h0A5);
    add("d2_wr_c8", 1'b1, 2'b00, 8'hC8,  8, 32'h55,   0,  32'h0);
    add("d2_rd_c8", 1'b1, 2'b01, 8'hC8, 17, 32'h0,    0,  32'h0);
    add("d2_st",    1'b1, 2'b10, 8'h00,  8, 32'h0,    8,  32'h80);
    add("d2_wr_c7", 1'b1, 2'b00, 8'hC7, 16, 32'h1234, 0,  32'h0);
    add("d2_rd_c7", 1'b1, 2'b01, 8'hC7, 17, 32'h0,    17, 32'h01234);
    add("wr_sat",   1'b0, 2'b00, 8'h80, 1040, 32'h0,  0,  32'h0);
    add("st_sat",   1'b0, 2'b10, 8'h00,  8, 32'h0,    8,  32'h7F);

    for (int n = 0; n < vecs.size(); n++) begin
      if (n == split) begin
        sel = 1'b0;
        reset_seq();
      end
      sel = vecs[n].sel;
      for (int i = 0; i < vecs[n].nbits; i++) begin
        if (i < vecs[n].nexp) exp_q.push_back(vecs[n].expbits[vecs[n].nexp - 1 - i]);
        else exp_q.push_back(1'b0);
      end
      txn(vecs[n].name, vecs[n].cmd, vecs[n].addr, vecs[n].nbits, vecs[n].wbits);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
